buzzer_sequencer: RTL
=====================

# buzzer_sequencer

Controller that drives the buzzer datapath's `note_div` and `vol_data` inputs. It arbitrates between three manual note keys and an internal melody playback engine, and owns the volume level set by the up/down buttons. It sits between the board inputs and the buzzer tone generator. All outputs are registered.

## Interface
Parameters:
- `TICK_DIV`, default 25_000_000: clock cycles per duration tick.
- `GAP_TICKS`, default 1: silent ticks inserted after every melody note.
- `VOL_STEP`, default 16'h0600: amplitude increment per volume level.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `key_do`, `key_re`, `key_me` in 1 each: manual note keys, active-low, already debounced.
- `vol_up_n`, `vol_down_n` in 1 each: volume buttons, active-low, debounced. Each falling edge is one step.
- `play_n` in 1: play/stop button, active-low. Acts on the falling edge.
- `note_div` out 20: half-period divider for the tone generator. 0 means silent.
- `vol_data` out 32: `{high amplitude, low amplitude}` pair for the tone generator.
- `vol_level` out 5: current volume, 0..16.
- `led` out 16: volume thermometer.
- `busy` out 1: high while the melody is playing.

## Operation
- **States:** IDLE, MANUAL, PLAY_NOTE, PLAY_GAP.
- **IDLE and MANUAL (manual path):**
  - Key priority is Do > Re > Me.
  - Note values: Do = 153256, Re = 136518, Me = 121212.
  - Any key low moves IDLE to MANUAL. All keys high moves MANUAL to IDLE.
  - `note_div` follows the highest-priority key.
- **Starting and stopping playback:**
  - A `play_n` falling edge in IDLE or MANUAL loads melody index 0 and enters PLAY_NOTE.
  - A `play_n` falling edge in PLAY_NOTE or PLAY_GAP aborts to IDLE.
  - Keys are ignored during playback.
- **Melody ROM:** 16 entries of `{code[1:0], dur[3:0]}`.
  - Codes: 0 = rest, 1 = Do, 2 = Re, 3 = Me.
  - `dur` = 0 marks end of song.
- **Playback sequencing:**
  - PLAY_NOTE outputs the entry's note for `dur`·`TICK_DIV` cycles, then enters PLAY_GAP.
  - PLAY_GAP outputs silence for `GAP_TICKS`·`TICK_DIV` cycles, then increments the index and returns to PLAY_NOTE.
  - If `GAP_TICKS` = 0, PLAY_GAP is skipped.
  - An end-of-song entry, or the index wrapping past 15, ends the song (see Configuration).
- **Volume:**
  - `vol_up_n` falling edge: `vol_level` +1, saturating at 16.
  - `vol_down_n` falling edge: `vol_level` −1, saturating at 0.
  - Simultaneous falling edges on both buttons: no change.
  - Volume is adjustable in every state.
- **Amplitude:**
  - amp = `vol_level`·`VOL_STEP`, 16-bit unsigned. 16·0x0600 = 0x6000, so no overflow.
  - `vol_data` = `{amp, −amp}` in two's complement.
  - `vol_data` = 0 whenever `note_div` = 0 or `vol_level` = 0.
- **LEDs:** `led[i]` = (i < `vol_level`). `led[15:0]` is all ones at level 16.

## Timing
- Reset values: `note_div` 0, `vol_data` 0, `vol_level` 0, `led` 0, `busy` 0, state IDLE, index 0, tick counter 0. Button edge-detect registers reset to 1 (released).
- Manual key to `note_div`: 1 cycle.
- Button edge to `vol_level`/`led`: 2 cycles (edge register, then level register).
- `vol_data` tracks `vol_level` and `note_div` with 1 further cycle.
- Tick counter:
  - Clears on every state entry.
  - Produces a tick when it reaches `TICK_DIV`−1.
  - Note and gap lengths are exact to the cycle.
- `busy` rises 1 cycle after the accepted play edge. It falls in the same cycle the state returns to IDLE.
- Reset asserted mid-song returns everything to reset values immediately.

## Configuration
- `BUZZER_SEQ_LOOP_EN` defined: end of song restarts at index 0 in PLAY_NOTE. Only a `play_n` edge or reset stops playback.
- `BUZZER_SEQ_LOOP_EN` undefined: end of song returns to IDLE and deasserts `busy`.

## Structure
- **Shared `buzzer_pkg`:**
  - Note divider constants (153256, 136518, 121212).
  - Note code constants.
  - State type.
  - Default `VOL_STEP`.
  - ROM entry width.
- **Sub-module `melody_rom`:** combinational 16×6 lookup, index in, `{code, dur}` out.
- The sequencer FSM, tick counter, edge detectors and volume logic live in `buzzer_sequencer`.

## Test plan
All scenarios use `TICK_DIV` = 4 and `GAP_TICKS` = 1.
- Reset check: assert `rst` mid-operation, then release → all outputs 0 and state IDLE.
- Manual arbitration: hold `key_re` low, then also `key_do` low → `note_div` 136518, then 153256 one cycle later; release both → 0.
- Volume: 3 `vol_up_n` pulses → `vol_level` 3, `led` 16'h0007, `vol_data` {16'h1200, 16'hEE00} with `key_me` held. 20 up pulses → `vol_level` 16, `led` 16'hFFFF.
- Simultaneous buttons: `vol_up_n` and `vol_down_n` fall in the same cycle → level unchanged. 20 down pulses → level 0 and `vol_data` 0.
- Playback: ROM {Do/2, Me/1, end}, press `play_n` → Do for 8 cycles, silence 4, Me 4, silence 4, then IDLE with `busy` low. With `BUZZER_SEQ_LOOP_EN` defined, Do restarts instead.
- Abort: press `play_n` during the second note → IDLE on the next cycle, `note_div` 0, keys are honoured again.

Source files
------------

// File: rtl/buzzer_pkg.sv
// buzzer_pkg -- shared definitions for the buzzer sequencer slice.
//   * tone-generator half-period dividers for the three playable notes
//   * melody ROM entry layout ({code[1:0], dur[3:0]}) and note codes
//   * sequencer state type, default per-level amplitude step
//   * code_to_div(): maps a note code to its divider (rest -> 0 = silent)
package buzzer_pkg;

  localparam int NOTE_W    = 20;
  localparam int CODE_W    = 2;
  localparam int DUR_W     = 4;
  localparam int ROM_W     = CODE_W + DUR_W;
  localparam int IDX_W     = 4;

  localparam logic [NOTE_W-1:0] NOTE_DO_DIV = 20'd153256;
  localparam logic [NOTE_W-1:0] NOTE_RE_DIV = 20'd136518;
  localparam logic [NOTE_W-1:0] NOTE_ME_DIV = 20'd121212;

  localparam logic [CODE_W-1:0] CODE_REST = 2'd0;
  localparam logic [CODE_W-1:0] CODE_DO   = 2'd1;
  localparam logic [CODE_W-1:0] CODE_RE   = 2'd2;
  localparam logic [CODE_W-1:0] CODE_ME   = 2'd3;

  localparam logic [15:0] DEF_VOL_STEP = 16'h0600;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MANUAL,
    ST_PLAY_NOTE,
    ST_PLAY_GAP
  } state_t;

  function automatic logic [NOTE_W-1:0] code_to_div(input logic [CODE_W-1:0] code);
    logic [NOTE_W-1:0] div;
    case (code)
      CODE_DO: div = NOTE_DO_DIV;
      CODE_RE: div = NOTE_RE_DIV;
      CODE_ME: div = NOTE_ME_DIV;
      default: div = '0;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// melody_rom -- combinational 16 x 6 melody table.
//   addr  in  4 : melody index
//   entry out 6 : {code[1:0], dur[3:0]}; dur == 0 marks end of song
// Unused slots hold end-of-song markers so a short tune terminates cleanly.
module melody_rom
  import buzzer_pkg::*;
(
  input  logic [IDX_W-1:0] addr,
  output logic [ROM_W-1:0] entry
);

  always_comb begin
    entry = {CODE_REST, 4'd0};
    case (addr)
      4'd0:    entry = {CODE_DO, 4'd2};
      4'd1:    entry = {CODE_ME, 4'd1};
      default: entry = {CODE_REST, 4'd0};
    endcase
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer -- drives note_div / vol_data of the buzzer tone generator.
// Arbitrates three manual keys (Do > Re > Me) against a ROM melody player and
// owns the volume level. All outputs registered; reset is asynchronous.
//   clk, rst                   : clock, async active-high reset
//   key_do/key_re/key_me       : manual keys, active-low
//   vol_up_n/vol_down_n        : volume step buttons, active-low, falling edge
//   play_n                     : play/stop, active-low, falling edge
//   note_div[19:0]             : tone half-period divider, 0 = silent
//   vol_data[31:0]             : {amp, -amp}, 0 when silent or level 0
//   vol_level[4:0], led[15:0]  : volume 0..16 and its thermometer
//   busy                       : melody playing
// Build option: define BUZZER_SEQ_LOOP_EN to restart the song at its end.
module buzzer_sequencer
  import buzzer_pkg::*;
#(
  parameter int          TICK_DIV  = 25_000_000,
  parameter int          GAP_TICKS = 1,
  parameter logic [15:0] VOL_STEP  = DEF_VOL_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_do,
  input  logic              key_re,
  input  logic              key_me,
  input  logic              vol_up_n,
  input  logic              vol_down_n,
  input  logic              play_n,
  output logic [NOTE_W-1:0] note_div,
  output logic [31:0]       vol_data,
  output logic [4:0]        vol_level,
  output logic [15:0]       led,
  output logic              busy
);

  localparam int             CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int             TW        = 16;
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [TW-1:0]     tnum_q, tnum_d;
  logic [NOTE_W-1:0] note_div_q, note_div_d;
  logic [31:0]       vol_data_q, vol_data_d;
  logic [4:0]        vol_level_q, vol_level_d;
  logic [15:0]       led_q, led_d;
  logic              busy_q, busy_d;
  logic              up_q, up_d, up_prev_q, up_prev_d;
  logic              dn_q, dn_d, dn_prev_q, dn_prev_d;
  logic              play_prev_q, play_prev_d;

  logic [ROM_W-1:0]  cur_entry, nxt_entry, first_entry;
  logic [CODE_W-1:0] cur_code, nxt_code, first_code, play_code;
  logic [DUR_W-1:0]  cur_dur, nxt_dur, first_dur;
  logic              tick, note_done, gap_done, end_next;
  logic              play_fall, up_fall, dn_fall, any_key;
  logic              advance, restart;
  logic [15:0]       amp;

  assign idx_inc = idx_q + 4'd1;

  // Three lookups: the current note, the one after it, and the song start,
  // so transitions can skip end markers without a combinational loop.
  melody_rom u_rom_cur   (.addr(idx_q),   .entry(cur_entry));
  melody_rom u_rom_nxt   (.addr(idx_inc), .entry(nxt_entry));
  melody_rom u_rom_first (.addr(4'd0),    .entry(first_entry));

  assign {cur_code, cur_dur}     = cur_entry;
  assign {nxt_code, nxt_dur}     = nxt_entry;
  assign {first_code, first_dur} = first_entry;

  assign tick      = (cyc_q == TICK_LAST);
  assign note_done = tick && ((tnum_q + 16'd1) == TW'(cur_dur));
  assign gap_done  = tick && ((tnum_q + 16'd1) == TW'(GAP_TICKS));
  assign end_next  = (idx_q == '1) || (nxt_dur == '0);

  // Volume buttons pass through two registers (edge detect on registered
  // samples); play acts on the raw input so busy follows in one cycle.
  assign up_fall   = up_prev_q & ~up_q;
  assign dn_fall   = dn_prev_q & ~dn_q;
  assign play_fall = play_prev_q & ~play_n;
  assign any_key   = ~(key_do & key_re & key_me);

  always_comb begin
    up_d        = vol_up_n;
    up_prev_d   = up_q;
    dn_d        = vol_down_n;
    dn_prev_d   = dn_q;
    play_prev_d = play_n;
  end

  // Sequencer next state
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    play_code = cur_code;
    advance   = 1'b0;
    restart   = 1'b0;
    cyc_d     = '0;
    tnum_d    = '0;
    if (state_q == ST_PLAY_NOTE || state_q == ST_PLAY_GAP) begin
      cyc_d  = tick ? '0 : cyc_q + 1'b1;
      tnum_d = tick ? tnum_q + 16'd1 : tnum_q;
    end

    case (state_q)
      ST_IDLE, ST_MANUAL: begin
        if (play_fall && first_dur != '0) begin
          state_d   = ST_PLAY_NOTE;
          idx_d     = '0;
          play_code = first_code;
          restart   = 1'b1;
        end else if (any_key) begin
          state_d = ST_MANUAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY_NOTE: begin
        if (play_fall) begin
          state_d = ST_IDLE;
        end else if (note_done) begin
          if (GAP_TICKS > 0) begin
            state_d = ST_PLAY_GAP;
            restart = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_PLAY_GAP: begin
        if (play_fall) state_d = ST_IDLE;
        else if (gap_done) advance = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      restart = 1'b1;
      if (!end_next) begin
        state_d   = ST_PLAY_NOTE;
        idx_d     = idx_inc;
        play_code = nxt_code;
      end
`ifdef BUZZER_SEQ_LOOP_EN
      else if (first_dur != '0) begin
        state_d   = ST_PLAY_NOTE;
        idx_d     = '0;
        play_code = first_code;
      end
`endif
      else begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    end

    // Each state entry starts a fresh, cycle-exact interval.
    if (restart) begin
      cyc_d  = '0;
      tnum_d = '0;
    end
  end

  // Registered outputs, derived from the state being entered
  always_comb begin
    note_div_d = '0;
    if (state_d == ST_MANUAL) begin
      if (!key_do)      note_div_d = NOTE_DO_DIV;
      else if (!key_re) note_div_d = NOTE_RE_DIV;
      else if (!key_me) note_div_d = NOTE_ME_DIV;
    end else if (state_d == ST_PLAY_NOTE) begin
      note_div_d = code_to_div(play_code);
    end
    busy_d = (state_d == ST_PLAY_NOTE) || (state_d == ST_PLAY_GAP);

    vol_level_d = vol_level_q;
    if (up_fall && !dn_fall && vol_level_q != 5'd16)
      vol_level_d = vol_level_q + 5'd1;
    else if (dn_fall && !up_fall && vol_level_q != 5'd0)
      vol_level_d = vol_level_q - 5'd1;

    // vol_data looks at the registered level/note, hence one cycle behind them.
    amp        = 16'({11'd0, vol_level_q} * VOL_STEP);
    vol_data_d = (note_div_q == '0 || vol_level_q == '0) ? 32'd0 : {amp, 16'd0 - amp};
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_led
    assign led_d[gi] = (5'(gi) < vol_level_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cyc_q       <= '0;
      tnum_q      <= '0;
      note_div_q  <= '0;
      vol_data_q  <= '0;
      vol_level_q <= '0;
      led_q       <= '0;
      busy_q      <= 1'b0;
      up_q        <= 1'b1;
      up_prev_q   <= 1'b1;
      dn_q        <= 1'b1;
      dn_prev_q   <= 1'b1;
      play_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cyc_q       <= cyc_d;
      tnum_q      <= tnum_d;
      note_div_q  <= note_div_d;
      vol_data_q  <= vol_data_d;
      vol_level_q <= vol_level_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      up_q        <= up_d;
      up_prev_q   <= up_prev_d;
      dn_q        <= dn_d;
      dn_prev_q   <= dn_prev_d;
      play_prev_q <= play_prev_d;
    end
  end

  assign note_div  = note_div_q;
  assign vol_data  = vol_data_q;
  assign vol_level = vol_level_q;
  assign led       = led_q;
  assign busy      = busy_q;

endmodule
